// File: rtl/ioctl_dn_pkg.sv
// Shared types and constants for the ioctl download sequencer.
package ioctl_dn_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} dn_state_e;

   localparam logic [15:0] CRC_POLY  = 16'h1021;
   localparam logic [15:0] CRC_INIT  = 16'hFFFF;
   localparam int          DN_ADDR_W = 17;

   typedef struct packed {
      logic [DN_ADDR_W-1:0] addr;
      logic [7:0]           data;
   } dn_entry_t;

   // CRC-16/CCITT-FALSE step over one byte, MSB first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/ioctl_dn_sequencer_fifo.sv
// Show-ahead synchronous FIFO of download entries; rd_entry is valid whenever !empty.
module dn_fifo
   import ioctl_dn_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk_sys,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  dn_entry_t                wr_entry,
   output dn_entry_t                rd_entry,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int             PW       = $clog2(DEPTH);
   localparam logic [PW:0]    FULL_LVL = (PW+1)'(DEPTH);

   dn_entry_t      mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW:0]    count;

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

   // NOTE: storage is deliberately not reset; pointers and count define validity.
   always_ff @(posedge clk_sys) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   assign rd_entry = mem[rd_ptr];
   assign full     = (count == FULL_LVL);
   assign empty    = (count == '0);
   assign level    = count;

endmodule

// File: rtl/ioctl_dn_sequencer.sv
// Buffers HPS ioctl download bytes and drains them to the target with a ready handshake.
// Optional feature: define DN_CRC_EN to build the CRC-16/CCITT-FALSE of each download.
module ioctl_dn_sequencer
   import ioctl_dn_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = DN_ADDR_W
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic [7:0]        ioctl_index,
   output logic              ioctl_wait,
   input  logic              dn_ready,
   output logic              dn_wr,
   output logic [ADDR_W-1:0] dn_addr,
   output logic [7:0]        dn_data,
   output logic [7:0]        dn_index,
   output logic              dn_active,
   output logic              dn_done,
   output logic [24:0]       dn_count,
   output logic              dn_err,
   output logic [15:0]       dn_crc
);

   localparam int          LW         = $clog2(FIFO_DEPTH);
   localparam logic [LW:0] WAIT_LEVEL = (LW+1)'(FIFO_DEPTH - 2);

   dn_state_e         state, state_next;
   logic              dl_q, pending;
   logic              rise, fall, start;
   logic              push_try, range_bad, push_ok, drop, pop;
   logic              full, empty;
   logic [LW:0]       level, level_next;
   dn_entry_t         wr_entry, rd_entry;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        data_q;

   dn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .push     (push_ok),
      .pop      (pop),
      .wr_entry (wr_entry),
      .rd_entry (rd_entry),
      .full     (full),
      .empty    (empty),
      .level    (level)
   );

   // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
   always_comb begin
      rise       = ioctl_download & ~dl_q;
      fall       = ~ioctl_download & dl_q;
      push_try   = ioctl_wr & ((state == LOAD) | (state == FLUSH));
      range_bad  = |ioctl_addr[24:ADDR_W];
      pop        = ~empty & dn_ready;
      // A full FIFO still takes the byte when an entry leaves in the same cycle.
      push_ok    = push_try & ~range_bad & ~(full & ~pop);
      drop       = push_try & ~push_ok;
      level_next = level + {{LW{1'b0}}, push_ok} - {{LW{1'b0}}, pop};
      wr_entry   = '{addr: ioctl_addr[ADDR_W-1:0], data: ioctl_dout};
      start      = ((state == IDLE) & rise) | ((state == DONE) & (pending | rise) & ~fall);
      state_next = state;
      case (state)
         IDLE:  if (rise) state_next = LOAD;
         LOAD:  if (fall) state_next = FLUSH;
         FLUSH: if (empty & ~push_ok) state_next = DONE;
         DONE:  state_next = start ? LOAD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state      <= IDLE;
         dl_q       <= 1'b0;
         pending    <= 1'b0;
         ioctl_wait <= 1'b0;
         dn_index   <= '0;
         dn_count   <= '0;
         dn_err     <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         state      <= state_next;
         dl_q       <= ioctl_download;
         ioctl_wait <= (level_next >= WAIT_LEVEL);
         // A restart request during drain is remembered until DONE consumes it.
         pending    <= (state == FLUSH) ? ((pending | rise) & ~fall) : 1'b0;
         if (start) begin
            dn_index <= ioctl_index;
            dn_count <= '0;
            dn_err   <= 1'b0;
         end else begin
            if (pop && dn_count != '1) dn_count <= dn_count + 25'd1;
            if (drop) dn_err <= 1'b1;
         end
         if (pop) begin
            addr_q <= rd_entry.addr;
            data_q <= rd_entry.data;
         end
      end
   end

`ifdef DN_CRC_EN
   logic [15:0] crc_run;

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         crc_run <= CRC_INIT;
         dn_crc  <= '0;
      end else begin
         if (start)    crc_run <= CRC_INIT;
         else if (pop) crc_run <= crc16_byte(crc_run, rd_entry.data);
         if (state == DONE) dn_crc <= crc_run;
      end
   end
`else
   assign dn_crc = 16'h0000;
`endif

   assign dn_wr     = pop;
   assign dn_addr   = pop ? rd_entry.addr : addr_q;
   assign dn_data   = pop ? rd_entry.data : data_q;
   assign dn_active = (state != IDLE);
   assign dn_done   = (state == DONE);

endmodule

// File: tb/tb_ioctl_dn_sequencer.sv
// Randomized and directed bench for ioctl_dn_sequencer against a queue-based download model.
module tb_ioctl_dn_sequencer;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic [7:0]  ioctl_index = '0;
   logic        dn_ready = 1'b0;
   logic        ioctl_wait, dn_wr, dn_active, dn_done, dn_err;
   logic [16:0] dn_addr;
   logic [7:0]  dn_data, dn_index;
   logic [24:0] dn_count;
   logic [15:0] dn_crc;

   int total = 0;
   int bad   = 0;
   int wr_seen = 0;
   int done_seen = 0;
   bit chk_en = 1'b0;

`ifdef DN_CRC_EN
   localparam logic [15:0] VEC_CRC = 16'h29B1;
`else
   localparam logic [15:0] VEC_CRC = 16'h0000;
`endif

   always #5 clk_sys = ~clk_sys;

   ioctl_dn_sequencer dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .dn_ready(dn_ready),
      .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data), .dn_index(dn_index),
      .dn_active(dn_active), .dn_done(dn_done), .dn_count(dn_count),
      .dn_err(dn_err), .dn_crc(dn_crc)
   );

   // Reference model: phase 0=idle 1=loading 2=draining 3=finished.
   typedef struct { int addr; int data; } ent_t;
   ent_t        mq[$];
   int          m_phase = 0;
   bit          m_dl = 0, m_pending = 0, m_wait = 0, m_err = 0;
   int          m_count = 0, m_index = 0, m_last_addr = 0, m_last_data = 0;
   logic [15:0] m_crc_run = 16'hFFFF, m_crc_out = 16'h0000;

   function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
      logic fb;
      for (int i = 7; i >= 0; i--) begin
         fb = c[15] ^ b[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   task automatic model_step();
      bit rise, fall, pop, attempt, pushed, start;
      int n0;
      ent_t e;
      if (!reset_n) begin
         mq.delete();
         m_phase = 0; m_dl = 0; m_pending = 0; m_wait = 0; m_err = 0;
         m_count = 0; m_index = 0; m_last_addr = 0; m_last_data = 0;
         m_crc_run = 16'hFFFF; m_crc_out = 16'h0000;
         return;
      end
      n0      = mq.size();
      rise    = ioctl_download && !m_dl;
      fall    = !ioctl_download && m_dl;
      pop     = n0 > 0 && dn_ready;
      attempt = ioctl_wr && (m_phase == 1 || m_phase == 2);
      pushed  = 0;
      if (attempt) begin
         if ((ioctl_addr >> 17) != 0 || (n0 == 8 && !pop)) m_err = 1;
         else pushed = 1;
      end
      if (pop) begin
         e = mq.pop_front();
         m_crc_run = crc_ref(m_crc_run, 8'(e.data));
         if (m_count < 32'h1FFFFFF) m_count++;
         m_last_addr = e.addr; m_last_data = e.data;
      end
      if (pushed) mq.push_back('{int'(ioctl_addr), int'(ioctl_dout)});
      start = (m_phase == 0 && rise) || (m_phase == 3 && (m_pending || rise) && !fall);
      case (m_phase)
         0: if (rise) m_phase = 1;
         1: if (fall) m_phase = 2;
         2: begin
            if (n0 == 0 && !pushed) m_phase = 3;
            m_pending = (m_pending || rise) && !fall;
         end
         default: begin
            m_crc_out = m_crc_run;
            m_phase   = start ? 1 : 0;
            m_pending = 0;
         end
      endcase
      if (start) begin
         m_count = 0; m_err = 0; m_crc_run = 16'hFFFF; m_index = ioctl_index;
      end
      m_wait = mq.size() >= 6;
      m_dl   = ioctl_download;
   endtask

   task automatic monitor();
      logic [24:0] act [10];
      logic [24:0] exp [10];
      string       nm [10];
      bit          exp_wr;
      exp_wr = mq.size() > 0 && dn_ready;
      nm = '{"ioctl_wait", "dn_wr", "dn_addr", "dn_data", "dn_index",
             "dn_active", "dn_done", "dn_count", "dn_err", "dn_crc"};
      act = '{25'(ioctl_wait), 25'(dn_wr), 25'(dn_addr), 25'(dn_data), 25'(dn_index),
              25'(dn_active), 25'(dn_done), dn_count, 25'(dn_err), 25'(dn_crc)};
      exp[0] = 25'(m_wait);
      exp[1] = 25'(exp_wr);
      exp[2] = 25'(exp_wr ? mq[0].addr : m_last_addr);
      exp[3] = 25'(exp_wr ? mq[0].data : m_last_data);
      exp[4] = 25'(m_index);
      exp[5] = 25'(m_phase != 0);
      exp[6] = 25'(m_phase == 3);
      exp[7] = 25'(m_count);
      exp[8] = 25'(m_err);
`ifdef DN_CRC_EN
      exp[9] = 25'(m_crc_out);
`else
      exp[9] = 25'(0);
`endif
      for (int i = 0; i < 10; i++) begin
         total++;
         if (act[i] !== exp[i]) begin
            bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm[i], $time, act[i], exp[i]);
         end
      end
      if (dn_wr === 1'b1) wr_seen++;
      if (dn_done === 1'b1) done_seen++;
   endtask

   initial forever begin @(posedge clk_sys); model_step(); end
   initial forever begin @(negedge clk_sys); if (chk_en) monitor(); end

   task automatic tick();
      @(posedge clk_sys); #1;
   endtask

   task automatic push_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic start_dl(input logic [7:0] idx);
      ioctl_index = idx; ioctl_download = 1'b1;
      tick();
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (1'b1) begin
         @(negedge clk_sys);
         if (dn_done === 1'b1) break;
         n++;
         if (n > limit) begin
            total++; bad++;
            $display("FAIL wait_done: no dn_done within %0d cycles", limit);
            break;
         end
      end
      tick();
   endtask

   task automatic expect_int(input string name, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(); tick();
      total++;
      if ({ioctl_wait, dn_wr, dn_addr, dn_data, dn_index, dn_active, dn_done,
           dn_count, dn_err, dn_crc} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got nonzero outputs wait=%b wr=%b active=%b count=%0d",
                  ioctl_wait, dn_wr, dn_active, dn_count);
      end
      reset_n = 1'b1;
      chk_en  = 1'b1;
      tick();
   endtask

   task automatic test_crc_vector();
      wr_seen = 0; done_seen = 0; dn_ready = 1'b1;
      start_dl(8'h02);
      for (int i = 0; i < 9; i++) push_byte(25'(i), 8'(8'h31 + i));
      ioctl_download = 1'b0;
      wait_done(60);
      expect_int("vec_writes", wr_seen, 9);
      expect_int("vec_done", done_seen, 1);
      expect_int("vec_index", int'(dn_index), 8'h02);
      expect_int("vec_count", int'(dn_count), 9);
      expect_int("vec_crc", int'(dn_crc), int'(VEC_CRC));
   endtask

   task automatic test_backpressure();
      dn_ready = 1'b0; wr_seen = 0;
      start_dl(8'h05);
      for (int i = 0; i < 5; i++) push_byte(25'(i), 8'($urandom));
      expect_int("bp_wait_at5", int'(ioctl_wait), 0);
      push_byte(25'd5, 8'($urandom));
      expect_int("bp_wait_at6", int'(ioctl_wait), 1);
      expect_int("bp_no_wr", wr_seen, 0);
      dn_ready = 1'b1;
      tick();
      expect_int("bp_wait_drop", int'(ioctl_wait), 0);
      ioctl_download = 1'b0;
      wait_done(40);
      expect_int("bp_writes", wr_seen, 6);
   endtask

   task automatic test_overflow();
      dn_ready = 1'b0; wr_seen = 0;
      start_dl(8'h07);
      for (int i = 0; i < 8; i++) push_byte(25'(i), 8'($urandom));
      expect_int("ovf_err_before", int'(dn_err), 0);
      push_byte(25'd8, 8'hEE);
      expect_int("ovf_err", int'(dn_err), 1);
      expect_int("ovf_no_wr", wr_seen, 0);
      dn_ready = 1'b1; ioctl_download = 1'b0;
      wait_done(40);
      expect_int("ovf_writes", wr_seen, 8);
      expect_int("ovf_count", int'(dn_count), 8);
   endtask

   task automatic test_range();
      dn_ready = 1'b1; wr_seen = 0;
      start_dl(8'h09);
      push_byte(25'h20000, 8'hA5);
      ioctl_download = 1'b0;
      wait_done(40);
      expect_int("rng_no_wr", wr_seen, 0);
      expect_int("rng_err", int'(dn_err), 1);
      start_dl(8'h0A);
      expect_int("rng_err_clr", int'(dn_err), 0);
      ioctl_download = 1'b0;
      wait_done(40);
   endtask

   task automatic test_reset_flush();
      dn_ready = 1'b0;
      start_dl(8'h33);
      for (int i = 0; i < 4; i++) push_byte(25'(i + 16), 8'($urandom));
      ioctl_download = 1'b0;
      tick();
      expect_int("rf_active", int'(dn_active), 1);
      reset_n = 1'b0;
      tick();
      total++;
      if ({ioctl_wait, dn_wr, dn_addr, dn_data, dn_index, dn_active, dn_done,
           dn_count, dn_err, dn_crc} !== '0) begin
         bad++;
         $display("FAIL rf_outputs: got nonzero outputs wait=%b active=%b index=%0h count=%0d",
                  ioctl_wait, dn_active, dn_index, dn_count);
      end
      reset_n = 1'b1; dn_ready = 1'b1; wr_seen = 0; done_seen = 0;
      repeat (20) tick();
      expect_int("rf_no_wr", wr_seen, 0);
      expect_int("rf_no_done", done_seen, 0);
   endtask

   task automatic test_restart();
      dn_ready = 1'b0;
      start_dl(8'h11);
      for (int i = 0; i < 3; i++) push_byte(25'(i), 8'($urandom));
      ioctl_download = 1'b0;
      tick(); tick();
      ioctl_index = 8'h22; ioctl_download = 1'b1;
      tick();
      dn_ready = 1'b1; wr_seen = 0; done_seen = 0;
      wait_done(40);
      expect_int("rs_done", done_seen, 1);
      expect_int("rs_writes", wr_seen, 3);
      expect_int("rs_active", int'(dn_active), 1);
      expect_int("rs_count", int'(dn_count), 0);
      expect_int("rs_index", int'(dn_index), 8'h22);
      ioctl_download = 1'b0;
      wait_done(40);
      expect_int("rs_done2", done_seen, 2);
   endtask

   task automatic test_random();
      int guard;
      bit ignore;
      done_seen = 0;
      for (int d = 0; d < 6; d++) begin
         dn_ready = ($urandom_range(0, 9) < 7);
         start_dl(8'($urandom));
         for (int i = 0; i < int'($urandom_range(5, 40)); i++) begin
            ignore = ($urandom_range(0, 3) == 0);
            guard  = 0;
            while (ioctl_wait && !ignore && guard < 200) begin
               dn_ready = ($urandom_range(0, 9) < 7);
               tick();
               guard++;
            end
            if (guard >= 200) begin
               total++; bad++;
               $display("FAIL rnd_wait: ioctl_wait stuck for %0d cycles", guard);
            end
            repeat ($urandom_range(0, 2)) begin
               dn_ready = ($urandom_range(0, 9) < 7);
               tick();
            end
            dn_ready = ($urandom_range(0, 9) < 7);
            push_byte(($urandom_range(0, 15) == 0) ? 25'(32'h20000 | $urandom_range(0, 255)) : 25'(i),
                      8'($urandom));
         end
         ioctl_download = 1'b0;
         dn_ready = 1'b1;
         wait_done(100);
      end
      expect_int("rnd_done", done_seen, 6);
   endtask

   initial begin
      test_reset();
      test_crc_vector();
      test_backpressure();
      test_overflow();
      test_range();
      test_reset_flush();
      test_restart();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
